// File: rtl/lock_pkg.sv
// Shared state encoding and default 50 MHz timing constants for the lock supervisor.
package lock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_OPENED  = 2'd1;
    localparam state_t ST_RELOCK  = 2'd2;
    localparam state_t ST_LOCKOUT = 2'd3;

    localparam int unsigned DEB_CYC_50M  = 1_000_000;
    localparam int unsigned OPEN_CYC_50M = 250_000_000;
    localparam int unsigned LOCK_CYC_50M = 1_500_000_000;

    localparam int unsigned TMR_W = 31;

endpackage

// File: rtl/lock_key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low key.
// Emits a one-cycle pulse when the debounced level falls.
module lock_key_debounce #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_fall
);

    localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    assign w_diff = (r_sync2 != r_level);
    assign w_done = w_diff && (r_cnt == CNT_W'(DEB_CYC - 32'd1));

    // Level is accepted once it differs from the debounced value for DEB_CYC samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_fall  <= w_done && !r_sync2;
            if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/lock_guard_ctrl.sv
// Supervisor between the push-buttons and the Lock_Password core: key debounce,
// auto-relock after the open window, failure counting and timed lockout.
module lock_guard_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned DEB_CYC  = DEB_CYC_50M,
    parameter int unsigned OPEN_CYC = OPEN_CYC_50M,
    parameter int unsigned LOCK_CYC = LOCK_CYC_50M,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            KEY_ENTER_N,
    input  logic                            KEY_PRESS_N,
    input  logic                            CORE_OPEN,
    input  logic                            CORE_ERROR,
    output logic                            CORE_ENTER_N,
    output logic                            CORE_PRESS_N,
    output logic                            CORE_RESET,
    output logic                            OPEN,
    output logic                            ALARM,
    output logic [$clog2(MAX_FAIL+1)-1:0]   FAIL_CNT
);

    localparam int unsigned FC_W = $clog2(MAX_FAIL + 1);

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [FC_W-1:0]   r_fail_cnt;
    logic              r_open_d;
    logic              r_err_d;
    logic              r_open_rise;
    logic              r_err_rise;
    logic              r_enter_n;
    logic              r_press_n;
    logic              r_core_reset;
    logic              r_open;
    logic              r_alarm;

    state_t            w_state_nxt;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic [FC_W-1:0]   w_fail_nxt;
    logic [FC_W-1:0]   w_fail_inc;
    logic              w_enter_fall;
    logic              w_press_fall;
    logic              w_idle;

    lock_key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_enter (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_key_n (KEY_ENTER_N),
        .o_fall  (w_enter_fall)
    );

    lock_key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_press (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_key_n (KEY_PRESS_N),
        .o_fall  (w_press_fall)
    );

    assign w_idle     = (r_state == ST_IDLE);
    assign w_fail_inc = (r_fail_cnt == FC_W'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + FC_W'(1);

    // Next-state logic; the shared timer counts down to zero in every timed state.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_fail_nxt  = r_fail_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_open_rise) begin
                    w_state_nxt = ST_OPENED;
                    w_fail_nxt  = '0;
                    w_timer_nxt = TMR_W'(OPEN_CYC - 32'd1);
                end else if (r_err_rise) begin
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == FC_W'(MAX_FAIL)) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_timer_nxt = TMR_W'(LOCK_CYC - 32'd1);
                    end
                end
            end
            ST_OPENED: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_RELOCK;
                    w_timer_nxt = TMR_W'(1);
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            ST_RELOCK: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_fail_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_fail_cnt   <= '0;
            r_open_d     <= 1'b0;
            r_err_d      <= 1'b0;
            r_open_rise  <= 1'b0;
            r_err_rise   <= 1'b0;
            r_enter_n    <= 1'b1;
            r_press_n    <= 1'b1;
            r_core_reset <= 1'b0;
            r_open       <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_open_d     <= CORE_OPEN;
            r_err_d      <= CORE_ERROR;
            r_open_rise  <= CORE_OPEN & ~r_open_d;
            r_err_rise   <= CORE_ERROR & ~r_err_d;
            r_enter_n    <= ~(w_enter_fall & w_idle);
            r_press_n    <= ~(w_press_fall & w_idle);
            r_core_reset <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_OPENED);
            r_open       <= (w_state_nxt == ST_OPENED);
            r_alarm      <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign CORE_ENTER_N = r_enter_n;
    assign CORE_PRESS_N = r_press_n;
    assign CORE_RESET   = r_core_reset;
    assign OPEN         = r_open;
    assign ALARM        = r_alarm;
    assign FAIL_CNT     = r_fail_cnt;

endmodule

// File: doc/lock_guard_ctrl.md
# lock_guard_ctrl

Supervisory controller placed between the DE2-115 push-buttons and the `Lock_Password` core.
- Debounces the raw ENTER/PRESS keys and delivers single-cycle active-low pulses to the core.
- Watches the core's OPEN/ERROR outputs, auto-relocks the core after a fixed open window, and counts consecutive failed entries.
- After `MAX_FAIL` failures, holds the core in reset and blocks all key input for a lockout period.

## Interface
Parameters:
- `DEB_CYC`, 1_000_000: cycles a synchronized key level must be stable to be accepted (20 ms at 50 MHz).
- `OPEN_CYC`, 250_000_000: cycles OPEN is held before automatic relock (5 s).
- `LOCK_CYC`, 1_500_000_000: lockout duration in cycles (30 s); timers are 31 bits.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout; range 1..15.

Ports:
- `CLK` in 1: CLOCK_50; the block's only clock.
- `RESET` in 1: synchronous, active-low.
- `KEY_ENTER_N` in 1: raw ENTER key, active-low, asynchronous to CLK.
- `KEY_PRESS_N` in 1: raw PRESS key, active-low, asynchronous to CLK.
- `CORE_OPEN` in 1: core OPEN output, active-high.
- `CORE_ERROR` in 1: core ERROR output, active-high.
- `CORE_ENTER_N` out 1: one-cycle active-low pulse to core ENTER.
- `CORE_PRESS_N` out 1: one-cycle active-low pulse to core PRESS.
- `CORE_RESET` out 1: active-low reset to the core.
- `OPEN` out 1: lock-open indication to LEDR[0].
- `ALARM` out 1: lockout indication to LEDR[1].
- `FAIL_CNT` out `$clog2(MAX_FAIL+1)`: current consecutive failure count.

## Operation
- **Key path:** each key passes through a 2-flop synchronizer, then a stability counter. The debounced level updates after `DEB_CYC` consecutive equal samples; any change restarts the count.
  - A debounced 1→0 transition is a key event.
  - Debounced level resets to 1, so a key held through reset yields one event after `DEB_CYC`.
- **Event forwarding:** events are forwarded only in IDLE. In any other state they are discarded, never queued. ENTER and PRESS events in the same cycle are both forwarded.
- **Core edges:** rising edges of `CORE_OPEN` and `CORE_ERROR` are detected with one register stage each.
- **IDLE:**
  - `CORE_OPEN` rise → OPENED; FAIL_CNT cleared; timer loaded with `OPEN_CYC-1`.
  - `CORE_ERROR` rise → FAIL_CNT+1. If the new value equals `MAX_FAIL`, go to LOCKOUT with timer `LOCK_CYC-1`; otherwise stay in IDLE.
  - If both rise in the same cycle, OPEN has priority and the error is ignored.
- **OPENED:** `OPEN`=1; timer decrements; at 0 → RELOCK.
- **RELOCK:** `CORE_RESET`=0 for exactly 2 cycles, then IDLE.
- **LOCKOUT:** `ALARM`=1 and `CORE_RESET`=0 throughout; timer decrements. At 0 → IDLE, with FAIL_CNT cleared, ALARM cleared and CORE_RESET released.
- **FAIL_CNT:** saturates at `MAX_FAIL`; it never wraps.

## Timing
- **Reset values** (while RESET=0 and on the first edge after): state IDLE, `CORE_ENTER_N`=1, `CORE_PRESS_N`=1, `CORE_RESET`=0, `OPEN`=0, `ALARM`=0, `FAIL_CNT`=0, timers 0.
  - `CORE_RESET` goes to 1 on the first clock after RESET returns high.
- **Reset mid-operation:** RESET low in any state aborts the timer and returns all outputs to the reset values on that edge.
- **Key latency:** key low → `CORE_ENTER_N`/`CORE_PRESS_N` low is 2 (sync) + `DEB_CYC` + 1 cycles. The pulse width is exactly 1 cycle.
- **OPEN:** registered; rises 2 cycles after `CORE_OPEN` rises (edge detect + state register). It stays high exactly `OPEN_CYC` cycles.
- **ALARM:** rises 2 cycles after the `MAX_FAIL`-th `CORE_ERROR` rise and stays high exactly `LOCK_CYC` cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `lock_pkg`:** state enum {IDLE, OPENED, RELOCK, LOCKOUT} and the default timing constants (`DEB_CYC_50M`, `OPEN_CYC_50M`, `LOCK_CYC_50M`).
- **Sub-module `lock_key_debounce`:** synchronizer, stability counter and falling-edge pulse. It has parameter `DEB_CYC` and is instantiated once per key.
- **Top:** FSM, shared 31-bit down-counter, failure counter and edge detectors live in `lock_guard_ctrl`.

## Test plan
Use `DEB_CYC`=4, `OPEN_CYC`=10, `LOCK_CYC`=20, `MAX_FAIL`=3.
- **Reset and debounce:**
  - Release RESET with keys high → `CORE_RESET` 0→1 one cycle later; all other outputs hold their reset values.
  - A `KEY_PRESS_N` low glitch of 3 cycles → no pulse.
  - A 10-cycle low → exactly one `CORE_PRESS_N` low pulse, 7 cycles after the key fell.
- **Open and relock:** pulse `CORE_OPEN` high in IDLE → `OPEN`=1 for exactly 10 cycles, then `CORE_RESET`=0 for 2 cycles, then IDLE; FAIL_CNT=0.
- **Lockout:**
  - Three `CORE_ERROR` rises → FAIL_CNT steps 1, 2, 3.
  - `ALARM` and `CORE_RESET`=0 for 20 cycles; key events during this window produce no core pulses.
  - Afterwards FAIL_CNT=0 and `ALARM`=0.
- **Simultaneous events:** `CORE_OPEN` and `CORE_ERROR` rise in the same cycle with FAIL_CNT=2 → OPENED entered, FAIL_CNT=0, `ALARM` stays 0.
- **Reset mid-operation:** assert RESET 5 cycles into LOCKOUT → next edge gives `ALARM`=0, FAIL_CNT=0, `CORE_RESET`=0, state IDLE.
- **Reset mid-OPENED:** assert RESET during OPENED → `OPEN`=0 on that edge; no relock sequence afterwards.
